dram_port_arbiter: RTL
======================

Name: dram_port_arbiter

Overview:
Shares the single user-area DRAM wishbone port between two requesters: the Caravel CPU (single-beat wishbone classic) and the DMA engine (incrementing bursts). It sits between the management wishbone/DMA block and the user DRAM. It arbitrates round-robin with burst lock, muxes address, data and control, and routes ack and read data back to the winner.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, byte address width
LEN_WIDTH, 8, DMA burst length field width (max burst 2^LEN_WIDTH-1 beats)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset. One clock; reset is synchronous and active-low.
cpu_cyc_i / cpu_stb_i / cpu_we_i  in  1 each  CPU wishbone request
cpu_sel_i  in  4  CPU byte enables
cpu_adr_i  in  ADDR_WIDTH  CPU address
cpu_dat_i  in  DATA_WIDTH  CPU write data
cpu_ack_o  out  1  CPU ack
cpu_dat_o  out  DATA_WIDTH  CPU read data
dma_req_i  in  1  DMA burst request (level, held until dma_done_o)
dma_we_i  in  1  burst direction, 1=write
dma_adr_i  in  ADDR_WIDTH  burst start byte address
dma_len_i  in  LEN_WIDTH  beat count
dma_dat_i  in  DATA_WIDTH  write data for current beat
dma_gnt_o  out  1  high while DMA owns the port
dma_ack_o  out  1  per-beat ack
dma_dat_o  out  DATA_WIDTH  per-beat read data
dma_done_o  out  1  one-cycle pulse at burst end
mem_cyc_o / mem_stb_o / mem_we_o  out  1 each  DRAM request
mem_sel_o  out  4  DRAM byte enables
mem_adr_o  out  ADDR_WIDTH  DRAM address
mem_dat_o  out  DATA_WIDTH  DRAM write data
mem_burst_o  out  1  high during DMA burst
mem_ack_i  in  1  DRAM ack
mem_dat_i  in  DATA_WIDTH  DRAM read data

Behaviour:
- States: IDLE, CPU, DMA, RELEASE. Reset (wb_rst_i low at clock edge) -> IDLE. All outputs are 0. Round-robin pointer favours CPU. Any transfer in flight is abandoned and no ack or done is issued.
- IDLE: CPU request = cpu_cyc_i & cpu_stb_i; DMA request = dma_req_i.
  - Exactly one request: grant it.
  - Both requesting: grant the pointer side. Pointer then flips to the other side.
  - Grant is registered. mem_* signals are valid starting the cycle after the request is sampled.
- CPU state: mem_cyc_o=mem_stb_o=1. mem_we/sel/adr/dat come from the cpu_* inputs, registered at grant.
  - cpu_ack_o = mem_ack_i, combinational in this state only. cpu_dat_o = mem_dat_i.
  - On mem_ack_i -> RELEASE.
- DMA state: latches dma_adr_i, dma_len_i and dma_we_i at grant.
  - dma_gnt_o=1, mem_burst_o=1, mem_sel_o=4'hF.
  - mem_adr_o = start + 4*beat. Beat counter is LEN_WIDTH bits. Address add wraps modulo 2^ADDR_WIDTH.
  - mem_dat_o = dma_dat_i, live.
  - Each mem_ack_i gives a dma_ack_o pulse (combinational) and dma_dat_o = mem_dat_i, then the beat advances.
  - Ack of the last beat -> dma_done_o pulse (registered, next cycle) and go to RELEASE.
  - mem_stb_o stays high across beats with no idle gap. CPU is locked out until the burst ends.
- dma_len_i=0: grant is taken, no mem_stb_o, dma_done_o pulses the cycle after grant, then RELEASE.
- RELEASE: one cycle, all mem_* = 0, no arbitration. This absorbs a stale cpu_stb_i or dma_req_i held for one cycle after ack/done. Then -> IDLE.
- mem_ack_i outside CPU/DMA is ignored. cpu_ack_o and dma_ack_o are never both high.
- Reset value of every output: 0.

Decomposition:
- Package dram_arb_pkg: state enum (IDLE/CPU/DMA/RELEASE), DMA_SEL=4'hF, ADDR_STRIDE=4, grant-side encoding.
- Sub-module rr_arbiter2: 2-request round-robin with pointer, update-enable and sync active-low reset.

Test Plan:
- CPU write adr 0x3800_0010, dat 0xDEADBEEF, sel 0xF; mem_ack_i 3 cycles after stb -> mem_stb_o rises the cycle after cpu_stb_i; cpu_ack_o is high exactly with mem_ack_i; mem_* are 0 the next cycle.
- DMA read adr 0x100, len 4, mem_ack_i every cycle -> mem_adr_o 0x100, 0x104, 0x108, 0x10C; 4 dma_ack_o pulses; dma_done_o the cycle after the 4th ack; mem_burst_o high throughout.
- CPU and DMA requesting together from reset -> CPU served first, then DMA after RELEASE. Repeat both requesting -> CPU first again, since the pointer flipped back after DMA won.
- CPU stb raised at DMA beat 1 of len 8 -> no cpu_ack_o until the burst's dma_done_o plus RELEASE; then the CPU transfer completes.
- wb_rst_i low during DMA beat 2 -> next cycle all outputs 0; no dma_done_o; state IDLE; pointer favours CPU.
- dma_len_i=0 -> dma_done_o one cycle after grant; mem_stb_o never asserted.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM port arbiter.
//   arb_state_t : arbiter FSM states
//   side_t      : grant-side encoding, also the bit index into the grant vector
//   DMA_SEL     : byte enables driven for every DMA beat (full word)
//   ADDR_STRIDE : byte increment between consecutive DMA beats
package dram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU     = 2'd1,
        ST_DMA     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        SIDE_CPU = 1'b0,
        SIDE_DMA = 1'b1
    } side_t;

    localparam logic [3:0] DMA_SEL     = 4'hF;
    localparam int         ADDR_STRIDE = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   gclk, grst_n : clock, synchronous active-low reset (pointer -> CPU side)
//   req[1:0]     : request vector, index = side_t
//   update_en    : when high and a grant is issued, the pointer moves to the
//                  side that did not win
//   gnt[1:0]     : one-hot grant, combinational from req and pointer
module rr_arbiter2
    import dram_arb_pkg::*;
(
    input  logic       gclk,
    input  logic       grst_n,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11)
            gnt[ptr] = 1'b1;
        else
            gnt = req;
    end

    // After any grant the loser (or idle side) gets priority next time.
    always_ff @(posedge gclk) begin
        if (!grst_n)
            ptr <= SIDE_CPU;
        else if (update_en && gnt != 2'b00)
            ptr <= ~gnt[SIDE_DMA];
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the user DRAM wishbone port between the CPU (single-beat classic)
// and the DMA engine (incrementing bursts, locked until done).
//   wb_clk_i, wb_rst_i : clock, synchronous active-low reset
//   cpu_*              : CPU wishbone slave side (request in, ack/data out)
//   dma_*              : DMA burst request in; grant, per-beat ack/data and
//                        end-of-burst done pulse out
//   mem_*              : wishbone master toward the DRAM
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cpu_cyc_i,
    input  logic                  cpu_stb_i,
    input  logic                  cpu_we_i,
    input  logic [3:0]            cpu_sel_i,
    input  logic [ADDR_WIDTH-1:0] cpu_adr_i,
    input  logic [DATA_WIDTH-1:0] cpu_dat_i,
    output logic                  cpu_ack_o,
    output logic [DATA_WIDTH-1:0] cpu_dat_o,
    input  logic                  dma_req_i,
    input  logic                  dma_we_i,
    input  logic [ADDR_WIDTH-1:0] dma_adr_i,
    input  logic [LEN_WIDTH-1:0]  dma_len_i,
    input  logic [DATA_WIDTH-1:0] dma_dat_i,
    output logic                  dma_gnt_o,
    output logic                  dma_ack_o,
    output logic [DATA_WIDTH-1:0] dma_dat_o,
    output logic                  dma_done_o,
    output logic                  mem_cyc_o,
    output logic                  mem_stb_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_sel_o,
    output logic [ADDR_WIDTH-1:0] mem_adr_o,
    output logic [DATA_WIDTH-1:0] mem_dat_o,
    output logic                  mem_burst_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_dat_i
);

    arb_state_t            state;
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  cpu_we_q;
    logic [3:0]            cpu_sel_q;
    logic [ADDR_WIDTH-1:0] cpu_adr_q;
    logic [DATA_WIDTH-1:0] cpu_dat_q;
    logic                  dma_we_q;
    logic [ADDR_WIDTH-1:0] dma_adr_q;
    logic [LEN_WIDTH-1:0]  dma_len_q;
    logic [LEN_WIDTH-1:0]  beat_q;
    logic                  in_cpu;
    logic                  in_dma;
    logic                  dma_active;
    logic [ADDR_WIDTH-1:0] beat_off;

    assign req[SIDE_CPU] = cpu_cyc_i & cpu_stb_i;
    assign req[SIDE_DMA] = dma_req_i;

    // Arbitration only happens from IDLE; RELEASE deliberately ignores requests.
    rr_arbiter2 u_rr (
        .gclk      (wb_clk_i),
        .grst_n    (wb_rst_i),
        .req       (req),
        .update_en (state == ST_IDLE),
        .gnt       (gnt)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state      <= ST_IDLE;
            cpu_we_q   <= 1'b0;
            cpu_sel_q  <= '0;
            cpu_adr_q  <= '0;
            cpu_dat_q  <= '0;
            dma_we_q   <= 1'b0;
            dma_adr_q  <= '0;
            dma_len_q  <= '0;
            beat_q     <= '0;
            dma_done_o <= 1'b0;
        end else begin
            dma_done_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (gnt[SIDE_CPU]) begin
                        cpu_we_q  <= cpu_we_i;
                        cpu_sel_q <= cpu_sel_i;
                        cpu_adr_q <= cpu_adr_i;
                        cpu_dat_q <= cpu_dat_i;
                        state     <= ST_CPU;
                    end else if (gnt[SIDE_DMA]) begin
                        dma_we_q  <= dma_we_i;
                        dma_adr_q <= dma_adr_i;
                        dma_len_q <= dma_len_i;
                        beat_q    <= '0;
                        state     <= ST_DMA;
                    end
                end
                ST_CPU: begin
                    if (mem_ack_i)
                        state <= ST_RELEASE;
                end
                ST_DMA: begin
                    // A zero-length burst holds the grant for one cycle only.
                    if (dma_len_q == '0) begin
                        dma_done_o <= 1'b1;
                        state      <= ST_RELEASE;
                    end else if (mem_ack_i) begin
                        if (beat_q == dma_len_q - LEN_WIDTH'(1)) begin
                            dma_done_o <= 1'b1;
                            state      <= ST_RELEASE;
                        end else begin
                            beat_q <= beat_q + LEN_WIDTH'(1);
                        end
                    end
                end
                ST_RELEASE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    assign in_cpu     = (state == ST_CPU);
    assign in_dma     = (state == ST_DMA);
    assign dma_active = in_dma && (dma_len_q != '0);
    // Address wraps naturally at the ADDR_WIDTH boundary.
    assign beat_off   = ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(ADDR_STRIDE);

    assign mem_cyc_o   = in_cpu | dma_active;
    assign mem_stb_o   = in_cpu | dma_active;
    assign mem_we_o    = in_cpu ? cpu_we_q : (dma_active & dma_we_q);
    assign mem_sel_o   = in_cpu ? cpu_sel_q : (dma_active ? DMA_SEL : 4'h0);
    assign mem_adr_o   = in_cpu ? cpu_adr_q : (dma_active ? dma_adr_q + beat_off : '0);
    assign mem_dat_o   = in_cpu ? cpu_dat_q : (dma_active ? dma_dat_i : '0);
    assign mem_burst_o = in_dma;

    assign cpu_ack_o = in_cpu & mem_ack_i;
    assign cpu_dat_o = in_cpu ? mem_dat_i : '0;
    assign dma_gnt_o = in_dma;
    assign dma_ack_o = dma_active & mem_ack_i;
    assign dma_dat_o = dma_active ? mem_dat_i : '0;

endmodule
